// File: rtl/pgm_sdram_arb.sv
// pgm_sdram_arb: shares the single SDRAM controller request channel between
// the PGM video fetcher, the 68000 bus and the Z80 bus (clk_sys domain).
// Video has fixed priority, the two CPUs alternate round-robin, and only one
// transaction is in flight at a time.
// Optional build macro: PGM_ARB_ANTISTARVE_EN lets a waiting CPU win after
// STARVE_MAX consecutive video grants.
module pgm_sdram_arb #(
  parameter int unsigned AW         = 24,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,

  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  input  logic              vid_we,
  input  logic [DW-1:0]     vid_wdata,
  input  logic [DW/8-1:0]   vid_be,
  output logic              vid_ack,
  output logic [DW-1:0]     vid_rdata,

  input  logic              m68k_req,
  input  logic [AW-1:0]     m68k_addr,
  input  logic              m68k_we,
  input  logic [DW-1:0]     m68k_wdata,
  input  logic [DW/8-1:0]   m68k_be,
  output logic              m68k_ack,
  output logic [DW-1:0]     m68k_rdata,

  input  logic              z80_req,
  input  logic [AW-1:0]     z80_addr,
  input  logic              z80_we,
  input  logic [DW-1:0]     z80_wdata,
  input  logic [DW/8-1:0]   z80_be,
  output logic              z80_ack,
  output logic [DW-1:0]     z80_rdata,

  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,

  output logic [2:0]        grant
);

  localparam int unsigned BW = DW / 8;

  // One-hot grant encodings {z80, m68k, vid}
  localparam logic [2:0] G_VID  = 3'b001;
  localparam logic [2:0] G_M68K = 3'b010;
  localparam logic [2:0] G_Z80  = 3'b100;

  // last_cpu encoding
  localparam logic CPU_M68K = 1'b0;
  localparam logic CPU_Z80  = 1'b1;

  // Reject out-of-range starvation limits at elaboration
  if (STARVE_MAX == 0 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("pgm_sdram_arb: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_cpu;
  logic            cpu_pend_c;
  logic            starve_hit_c;
  logic [2:0]      win_c;
  logic            grant_ld_c;
  logic            done_c;
  logic [AW-1:0]   sel_addr_c;
  logic            sel_we_c;
  logic [DW-1:0]   sel_wdata_c;
  logic [BW-1:0]   sel_be_c;

  assign cpu_pend_c = m68k_req | z80_req;

`ifdef PGM_ARB_ANTISTARVE_EN
  logic [3:0] starve_cnt;

  // A pending CPU overrides video once the video streak reaches the limit
  assign starve_hit_c = cpu_pend_c && (starve_cnt == 4'(STARVE_MAX));

  // Count video grants made while a CPU is kept waiting
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (grant_ld_c) begin
      if (win_c == G_VID && cpu_pend_c) begin
        starve_cnt <= 4'(starve_cnt + 4'd1);
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end
`else
  assign starve_hit_c = 1'b0;
`endif

  // Winner selection: video first, then round-robin between the CPUs
  always_comb begin
    win_c = 3'b000;
    if (vid_req && !starve_hit_c) begin
      win_c = G_VID;
    end else if (m68k_req && z80_req) begin
      win_c = (last_cpu == CPU_Z80) ? G_M68K : G_Z80;
    end else if (m68k_req) begin
      win_c = G_M68K;
    end else if (z80_req) begin
      win_c = G_Z80;
    end
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|win_c)  state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: grant load, completion strobe and winner field mux
  always_comb begin
    grant_ld_c  = (state == S_IDLE) && (|win_c);
    done_c      = (state == S_BUSY) && mem_ack;
    sel_addr_c  = vid_addr;
    sel_we_c    = vid_we;
    sel_wdata_c = vid_wdata;
    sel_be_c    = vid_be;
    if (win_c == G_M68K) begin
      sel_addr_c  = m68k_addr;
      sel_we_c    = m68k_we;
      sel_wdata_c = m68k_wdata;
      sel_be_c    = m68k_be;
    end else if (win_c == G_Z80) begin
      sel_addr_c  = z80_addr;
      sel_we_c    = z80_we;
      sel_wdata_c = z80_wdata;
      sel_be_c    = z80_be;
    end
  end

  // Registered downstream request, grant, round-robin pointer and responses
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      grant      <= 3'b000;
      last_cpu   <= CPU_Z80;
      vid_ack    <= 1'b0;
      m68k_ack   <= 1'b0;
      z80_ack    <= 1'b0;
      vid_rdata  <= '0;
      m68k_rdata <= '0;
      z80_rdata  <= '0;
    end else begin
      vid_ack  <= 1'b0;
      m68k_ack <= 1'b0;
      z80_ack  <= 1'b0;
      if (grant_ld_c) begin
        mem_req   <= 1'b1;
        grant     <= win_c;
        mem_addr  <= sel_addr_c;
        mem_we    <= sel_we_c;
        mem_wdata <= sel_wdata_c;
        mem_be    <= sel_be_c;
        if (win_c == G_M68K) begin
          last_cpu <= CPU_M68K;
        end else if (win_c == G_Z80) begin
          last_cpu <= CPU_Z80;
        end
      end
      if (done_c) begin
        mem_req  <= 1'b0;
        vid_ack  <= grant[0];
        m68k_ack <= grant[1];
        z80_ack  <= grant[2];
        if (grant[0]) vid_rdata  <= mem_rdata;
        if (grant[1]) m68k_rdata <= mem_rdata;
        if (grant[2]) z80_rdata  <= mem_rdata;
      end
      if (state == S_DONE) begin
        grant <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_pgm_sdram_arb.sv
// tb_pgm_sdram_arb: directed bench for the three-port SDRAM arbiter.
module tb_pgm_sdram_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;

  logic        vid_req = 1'b0, m68k_req = 1'b0, z80_req = 1'b0;
  logic [23:0] vid_addr = '0, m68k_addr = '0, z80_addr = '0;
  logic        vid_we = 1'b0, m68k_we = 1'b0, z80_we = 1'b0;
  logic [15:0] vid_wdata = '0, m68k_wdata = '0, z80_wdata = '0;
  logic [1:0]  vid_be = '0, m68k_be = '0, z80_be = '0;
  logic        vid_ack, m68k_ack, z80_ack;
  logic [15:0] vid_rdata, m68k_rdata, z80_rdata;

  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  pgm_sdram_arb dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_we     (vid_we),
    .vid_wdata  (vid_wdata),
    .vid_be     (vid_be),
    .vid_ack    (vid_ack),
    .vid_rdata  (vid_rdata),
    .m68k_req   (m68k_req),
    .m68k_addr  (m68k_addr),
    .m68k_we    (m68k_we),
    .m68k_wdata (m68k_wdata),
    .m68k_be    (m68k_be),
    .m68k_ack   (m68k_ack),
    .m68k_rdata (m68k_rdata),
    .z80_req    (z80_req),
    .z80_addr   (z80_addr),
    .z80_we     (z80_we),
    .z80_wdata  (z80_wdata),
    .z80_be     (z80_be),
    .z80_ack    (z80_ack),
    .z80_rdata  (z80_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .grant      (grant)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_reqs();
    vid_req  = 1'b0;
    m68k_req = 1'b0;
    z80_req  = 1'b0;
    vid_we   = 1'b0;
    m68k_we  = 1'b0;
    z80_we   = 1'b0;
  endtask

  task automatic reset_dut();
    clear_reqs();
    mem_ack = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Poll for mem_req with a bounded budget; no comparison here
  task automatic wait_mem_req(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    reset_n = 1'b0;
    step();
    step();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b expected 000", grant); end
    n_tests++; if ({mem_addr, mem_we, mem_wdata, mem_be} !== 43'd0) begin n_fail++; $display("FAIL reset_mem_fields: got %h expected 0", {mem_addr, mem_we, mem_wdata, mem_be}); end
    n_tests++; if ({z80_ack, m68k_ack, vid_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {z80_ack, m68k_ack, vid_ack}); end
    n_tests++; if ({vid_rdata, m68k_rdata, z80_rdata} !== 48'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {vid_rdata, m68k_rdata, z80_rdata}); end
    reset_n = 1'b1;
    step();
    // Stray mem_ack in IDLE must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    step();
    n_tests++; if (mem_req !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL idle_stray_ack: got req=%b grant=%b expected req=0 grant=000", mem_req, grant); end
    n_tests++; if ({z80_ack, m68k_ack, vid_ack, m68k_rdata} !== 19'd0) begin n_fail++; $display("FAIL idle_stray_ack_resp: got %h expected 0", {z80_ack, m68k_ack, vid_ack, m68k_rdata}); end
  endtask

  task automatic test_single_read();
    reset_dut();
    m68k_req  = 1'b1;
    m68k_addr = 24'h000100;
    m68k_we   = 1'b0;
    m68k_be   = 2'b11;
    step();  // cycle 1
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rd_c1_mem_req: got %b expected 1", mem_req); end
    n_tests++; if (mem_addr !== 24'h000100) begin n_fail++; $display("FAIL rd_c1_mem_addr: got %h expected 000100", mem_addr); end
    n_tests++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rd_c1_grant: got %b expected 010", grant); end
    n_tests++; if (mem_we !== 1'b0 || mem_be !== 2'b11) begin n_fail++; $display("FAIL rd_c1_we_be: got we=%b be=%b expected we=0 be=11", mem_we, mem_be); end
    step();  // cycle 2
    n_tests++; if (mem_req !== 1'b1 || grant !== 3'b010) begin n_fail++; $display("FAIL rd_c2_hold: got req=%b grant=%b expected req=1 grant=010", mem_req, grant); end
    step();  // cycle 3: controller completes
    n_tests++; if (grant !== 3'b010 || m68k_ack !== 1'b0) begin n_fail++; $display("FAIL rd_c3_hold: got grant=%b ack=%b expected grant=010 ack=0", grant, m68k_ack); end
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    step();  // cycle 4
    mem_ack = 1'b0;
    n_tests++; if (m68k_ack !== 1'b1) begin n_fail++; $display("FAIL rd_c4_ack: got %b expected 1", m68k_ack); end
    n_tests++; if (m68k_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_c4_rdata: got %h expected beef", m68k_rdata); end
    n_tests++; if (grant !== 3'b010 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_c4_grant_req: got grant=%b req=%b expected grant=010 req=0", grant, mem_req); end
    n_tests++; if ({z80_ack, vid_ack} !== 2'b00) begin n_fail++; $display("FAIL rd_c4_other_acks: got %b expected 00", {z80_ack, vid_ack}); end
    m68k_req = 1'b0;
    step();  // cycle 5: back in IDLE
    n_tests++; if (m68k_ack !== 1'b0 || grant !== 3'b000 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_c5_idle: got ack=%b grant=%b req=%b expected 0 000 0", m68k_ack, grant, mem_req); end
    step();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_no_regrant: got %b expected 0", mem_req); end
  endtask

  // Runs right after test_single_read: m68k_rdata must still hold beef
  task automatic test_write_and_late_req();
    z80_req   = 1'b1;
    z80_addr  = 24'hABCDE0;
    z80_we    = 1'b1;
    z80_wdata = 16'h1234;
    z80_be    = 2'b01;
    step();
    n_tests++; if (grant !== 3'b100 || mem_req !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got grant=%b req=%b expected 100 1", grant, mem_req); end
    n_tests++; if ({mem_addr, mem_we, mem_wdata, mem_be} !== {24'hABCDE0, 1'b1, 16'h1234, 2'b01}) begin n_fail++; $display("FAIL wr_fields: got %h expected %h", {mem_addr, mem_we, mem_wdata, mem_be}, {24'hABCDE0, 1'b1, 16'h1234, 2'b01}); end
    // Video arrives mid-transaction; ack accepted in first BUSY cycle
    vid_req   = 1'b1;
    vid_addr  = 24'h000555;
    vid_be    = 2'b11;
    mem_ack   = 1'b1;
    mem_rdata = 16'h5A5A;
    step();  // DONE
    mem_ack = 1'b0;
    n_tests++; if ({z80_ack, m68k_ack, vid_ack} !== 3'b100) begin n_fail++; $display("FAIL wr_ack: got %b expected 100", {z80_ack, m68k_ack, vid_ack}); end
    n_tests++; if (grant !== 3'b100) begin n_fail++; $display("FAIL wr_done_grant: got %b expected 100", grant); end
    n_tests++; if (m68k_rdata !== 16'hBEEF || z80_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL wr_rdata_hold: got m68k=%h z80=%h expected beef 5a5a", m68k_rdata, z80_rdata); end
    z80_req = 1'b0;
    z80_we  = 1'b0;
    step();  // IDLE
    n_tests++; if (grant !== 3'b000 || mem_req !== 1'b0) begin n_fail++; $display("FAIL late_req_wait: got grant=%b req=%b expected 000 0", grant, mem_req); end
    step();  // video granted
    n_tests++; if (grant !== 3'b001 || mem_addr !== 24'h000555) begin n_fail++; $display("FAIL late_req_grant: got grant=%b addr=%h expected 001 000555", grant, mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = 16'h0F0F;
    step();
    mem_ack = 1'b0;
    n_tests++; if (vid_ack !== 1'b1 || vid_rdata !== 16'h0F0F || z80_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL late_req_ack: got ack=%b vid=%h z80=%h expected 1 0f0f 5a5a", vid_ack, vid_rdata, z80_rdata); end
    vid_req = 1'b0;
    step();
  endtask

  task automatic test_cpu_tie();
    logic [2:0]  exp_g [6] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    logic [23:0] exp_a;
    bit          seen;
    reset_dut();
    m68k_req  = 1'b1;
    m68k_addr = 24'h000010;
    z80_req   = 1'b1;
    z80_addr  = 24'h000020;
    for (int i = 0; i < 6; i++) begin
      wait_mem_req(seen);
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL tie_timeout[%0d]: got no mem_req expected mem_req", i);
        break;
      end
      exp_a = (exp_g[i] == 3'b010) ? 24'h000010 : 24'h000020;
      n_tests++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
      n_tests++; if (mem_addr !== exp_a) begin n_fail++; $display("FAIL tie_addr[%0d]: got %h expected %h", i, mem_addr, exp_a); end
      mem_ack   = 1'b1;
      mem_rdata = 16'hC000 + 16'(i);
      step();
      mem_ack = 1'b0;
      n_tests++; if ({z80_ack, m68k_ack, vid_ack} !== exp_g[i]) begin n_fail++; $display("FAIL tie_ack[%0d]: got %b expected %b", i, {z80_ack, m68k_ack, vid_ack}, exp_g[i]); end
      if (i == 5) clear_reqs();
      step();
    end
    step();
  endtask

  task automatic test_priority();
    bit seen;
    int n_txn;
`ifdef PGM_ARB_ANTISTARVE_EN
    n_txn = 1;
`else
    n_txn = 11;
`endif
    reset_dut();
    vid_req  = 1'b1;
    vid_addr = 24'h000700;
    m68k_req = 1'b1;
    z80_req  = 1'b1;
    for (int i = 0; i < n_txn; i++) begin
      wait_mem_req(seen);
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL prio_timeout[%0d]: got no mem_req expected mem_req", i);
        break;
      end
      n_tests++; if (grant !== 3'b001) begin n_fail++; $display("FAIL prio_grant[%0d]: got %b expected 001", i, grant); end
      mem_ack   = 1'b1;
      mem_rdata = 16'hA000 + 16'(i);
      step();
      mem_ack = 1'b0;
      n_tests++; if (vid_ack !== 1'b1 || vid_rdata !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL prio_ack[%0d]: got ack=%b rdata=%h expected 1 %h", i, vid_ack, vid_rdata, 16'hA000 + 16'(i)); end
      if (i == n_txn - 1) clear_reqs();
      step();
    end
    step();
  endtask

`ifdef PGM_ARB_ANTISTARVE_EN
  task automatic test_antistarve();
    logic [2:0] exp_g [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                               3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    bit seen;
    reset_dut();
    vid_req  = 1'b1;
    m68k_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_mem_req(seen);
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL starve_timeout[%0d]: got no mem_req expected mem_req", i);
        break;
      end
      n_tests++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL starve_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      if (i == 9) clear_reqs();
      step();
    end
    step();
  endtask
`endif

  task automatic test_reset_mid_busy();
    reset_dut();
    m68k_req  = 1'b1;
    m68k_addr = 24'h000300;
    step();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got %b expected 1", mem_req); end
    reset_n  = 1'b0;
    m68k_req = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL midrst_async: got req=%b grant=%b expected 0 000", mem_req, grant); end
    step();
    #2;
    reset_n = 1'b1;
    step();
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if ({z80_ack, m68k_ack, vid_ack} !== 3'b000 || grant !== 3'b000 || mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_idle[%0d]: got acks=%b grant=%b req=%b expected 000 000 0", c, {z80_ack, m68k_ack, vid_ack}, grant, mem_req); end
      step();
    end
    n_tests++; if (m68k_rdata !== 16'h0000) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0000", m68k_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_and_late_req();
    test_cpu_tie();
    test_priority();
`ifdef PGM_ARB_ANTISTARVE_EN
    test_antistarve();
`endif
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
